// File: rtl/neptuno_audio_fifo.sv
// Stereo sample FIFO feeding the I2S transmitter: producer pushes pairs at its own rate,
// one pair is released to the transmitter per frame on the falling edge of lrclk.
module neptuno_audio_fifo #(
    parameter int AUDIO_DW   = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AUDIO_DW-1:0]   in_left,
    input  logic [AUDIO_DW-1:0]   in_right,
    input  logic                  lrclk,
    output logic [AUDIO_DW-1:0]   out_left,
    output logic [AUDIO_DW-1:0]   out_right,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  clr_flags,
    output logic                  underflow,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [2*AUDIO_DW-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  lrclk_d;
    logic                  primed;
    logic                  push;
    logic                  pop_evt;
    logic                  pop;
    logic [2*AUDIO_DW-1:0] head;

    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop_evt  = lrclk_d && !lrclk;
    assign pop      = pop_evt && (count != '0);
    assign head     = mem[rd_ptr];
    assign level    = count;

    // Storage carries no reset; a reset empties the FIFO through the pointers alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_left, in_right};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lrclk_d   <= 1'b1;
            primed    <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            lrclk_d <= lrclk;

            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                primed <= 1'b1;
            end

            if (pop) begin
                rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
                out_left  <= head[2*AUDIO_DW-1:AUDIO_DW];
                out_right <= head[AUDIO_DW-1:0];
            end

            if (push && !pop)
                count <= count + COUNT_ONE;
            else if (pop && !push)
                count <= count - COUNT_ONE;

            // A new error in the same cycle as a clear must not be lost.
            if (pop_evt && (count == '0) && primed)
                underflow <= 1'b1;
            else if (clr_flags)
                underflow <= 1'b0;

            if (in_valid && !in_ready)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neptuno_audio_fifo.sv
// Directed bench for neptuno_audio_fifo: priming, per-frame release, underflow/overflow
// flags, full/empty boundaries, same-cycle push+pop and mid-stream reset.
module tb_neptuno_audio_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        lrclk;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic [3:0]  level;
    logic        clr_flags;
    logic        underflow;
    logic        overflow;

    int check_count = 0;
    int error_count = 0;

    neptuno_audio_fifo #(.AUDIO_DW(16), .DEPTH_LOG2(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_left   (in_left),
        .in_right  (in_right),
        .lrclk     (lrclk),
        .out_left  (out_left),
        .out_right (out_right),
        .level     (level),
        .clr_flags (clr_flags),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic lrFall();
        lrclk = 1'b0;
        tick();
        lrclk = 1'b1;
        tick();
    endtask

    // Checks the falling-edge release lands exactly one clock after lrclk drops.
    task automatic lrFallTimed(input string tag, input logic [31:0] expected);
        lrclk = 1'b0;
        tick();
        checkOutput(tag, {out_left, out_right}, expected);
        lrclk = 1'b1;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        lrclk     = 1'b1;
        clr_flags = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        checkOutput("reset_out",       {out_left, out_right}, 32'h0);
        checkOutput("reset_level",     32'(level), 32'd0);
        checkOutput("reset_in_ready",  32'(in_ready), 32'd1);
        checkOutput("reset_underflow", 32'(underflow), 32'd0);
        checkOutput("reset_overflow",  32'(overflow), 32'd0);

        for (int i = 0; i < 4; i++) lrFall();
        checkOutput("unprimed_out",       {out_left, out_right}, 32'h0);
        checkOutput("unprimed_underflow", 32'(underflow), 32'd0);
        checkOutput("unprimed_level",     32'(level), 32'd0);

        applyStimulus(16'h1111, 16'hAAAA);
        applyStimulus(16'h2222, 16'hBBBB);
        applyStimulus(16'h3333, 16'hCCCC);
        checkOutput("three_level", 32'(level), 32'd3);
        checkOutput("three_out_before_pop", {out_left, out_right}, 32'h0);

        lrFallTimed("pop1_out", 32'h1111AAAA);
        checkOutput("pop1_level", 32'(level), 32'd2);
        lrFallTimed("pop2_out", 32'h2222BBBB);
        checkOutput("pop2_level", 32'(level), 32'd1);
        lrFallTimed("pop3_out", 32'h3333CCCC);
        checkOutput("pop3_level", 32'(level), 32'd0);

        lrFall();
        checkOutput("drain_hold_out",  {out_left, out_right}, 32'h3333CCCC);
        checkOutput("drain_underflow", 32'(underflow), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checkOutput("clr_underflow", 32'(underflow), 32'd0);

        for (int i = 0; i < 8; i++)
            applyStimulus(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        checkOutput("full_level",    32'(level), 32'd8);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_no_ovf",   32'(overflow), 32'd0);
        applyStimulus(16'hDEAD, 16'hBEEF);
        checkOutput("ovf_flag",  32'(overflow), 32'd1);
        checkOutput("ovf_level", 32'(level), 32'd8);

        lrFall();
        checkOutput("full_pop_level",    32'(level), 32'd7);
        checkOutput("full_pop_in_ready", 32'(in_ready), 32'd1);
        checkOutput("full_pop_out",      {out_left, out_right}, 32'h01000200);
        for (int i = 1; i < 8; i++) lrFall();
        checkOutput("full_drain_out",   {out_left, out_right}, 32'h01070207);
        checkOutput("full_drain_level", 32'(level), 32'd0);
        checkOutput("full_drain_ovf",   32'(overflow), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checkOutput("clr_overflow", 32'(overflow), 32'd0);

        // Empty and primed: push, pop event and clear all land in one cycle.
        in_valid  = 1'b1;
        in_left   = 16'h5555;
        in_right  = 16'hDDDD;
        lrclk     = 1'b0;
        clr_flags = 1'b1;
        tick();
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        lrclk     = 1'b1;
        tick();
        checkOutput("same_cycle_underflow", 32'(underflow), 32'd1);
        checkOutput("same_cycle_level",     32'(level), 32'd1);
        checkOutput("same_cycle_hold_out",  {out_left, out_right}, 32'h01070207);
        lrFall();
        checkOutput("same_cycle_next_out",   {out_left, out_right}, 32'h5555DDDD);
        checkOutput("same_cycle_next_level", 32'(level), 32'd0);

        for (int i = 0; i < 5; i++)
            applyStimulus(16'h0A00 + 16'(i), 16'h0B00 + 16'(i));
        checkOutput("pre_reset_level", 32'(level), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_reset_out",       {out_left, out_right}, 32'h0);
        checkOutput("mid_reset_level",     32'(level), 32'd0);
        checkOutput("mid_reset_underflow", 32'(underflow), 32'd0);
        checkOutput("mid_reset_in_ready",  32'(in_ready), 32'd1);
        tick();
        tick();
        checkOutput("post_reset_no_pop_out",   {out_left, out_right}, 32'h0);
        checkOutput("post_reset_no_pop_level", 32'(level), 32'd0);
        lrFall();
        checkOutput("post_reset_unprimed", 32'(underflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
